dlf_pi_loop_filter: RTL and testbench

- Parametrised second-generation digital loop filter for the DPLL path.
- Sits between the phase detector (lead/lag plus magnitude strobe) and the DCO/NCO control-word input.
- Supports two runtime modes:
  - K-counter mode: classic up/down counter emitting carry/borrow.
  - PI mode: proportional-integral mode with a saturating integrator.
- The control word is offset from a programmable centre word, with saturation reporting.

---
 rtl/dlf_pkg.sv | 32 +++
 rtl/dlf_kcounter.sv | 62 ++++++
 rtl/dlf_pi_loop_filter.sv | 125 ++++++++++++
 tb/tb_dlf_pi_loop_filter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/dlf_pkg.sv
// Shared constants and saturating arithmetic helpers for the DPLL loop filter.
package dlf_pkg;

  localparam logic MODE_KCNT = 1'b0;
  localparam logic MODE_PI   = 1'b1;

  // Signed add clamped to the two's-complement range of 'width' bits (width <= 31).
  function automatic logic signed [31:0] sat_add_s(input logic signed [31:0] a,
                                                    input logic signed [31:0] b,
                                                    input int width);
    logic signed [32:0] sum;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    sum = $signed({a[31], a}) + $signed({b[31], b});
    hi  = (33'sd1 <<< (width - 1)) - 33'sd1;
    lo  = -(33'sd1 <<< (width - 1));
    if (sum > hi)      return $signed(hi[31:0]);
    else if (sum < lo) return $signed(lo[31:0]);
    else               return $signed(sum[31:0]);
  endfunction

  // Clamp a signed value into the unsigned range [0, 2^width-1].
  function automatic logic [31:0] clamp_u(input logic signed [31:0] y,
                                          input int width);
    logic signed [31:0] hi;
    hi = (32'sd1 <<< width) - 32'sd1;
    if (y < 0)       return '0;
    else if (y > hi) return $unsigned(hi);
    else             return $unsigned(y);
  endfunction

endpackage

// File: rtl/dlf_kcounter.sv
// Up/down K-counter: stage 1 of the K-counter path, registering carry/borrow flags.
module dlf_kcounter #(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             step_i,
  input  logic             up_i,
  input  logic [ACC_W-2:0] k_mod_i,
  output logic             carry_o,
  output logic             borrow_o
);

  logic signed [ACC_W-1:0] cnt_q, cnt_d;
  logic                    carry_q, carry_d;
  logic                    borrow_q, borrow_d;
  logic [ACC_W-2:0]        k_eff;
  logic signed [ACC_W:0]   nxt, k_pos, k_neg;

  always_comb begin
    k_eff = (k_mod_i == '0) ? (ACC_W-1)'(1) : k_mod_i;
    k_pos = $signed({2'b00, k_eff});
    k_neg = -k_pos;
    if (up_i) nxt = (ACC_W+1)'(cnt_q) + (ACC_W+1)'(1);
    else      nxt = (ACC_W+1)'(cnt_q) - (ACC_W+1)'(1);

    cnt_d    = cnt_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (step_i) begin
      // >= / <= so a count left beyond a newly shrunk modulus still wraps.
      if (up_i && (nxt >= k_pos)) begin
        cnt_d   = '0;
        carry_d = 1'b1;
      end else if (!up_i && (nxt <= k_neg)) begin
        cnt_d    = '0;
        borrow_d = 1'b1;
      end else begin
        cnt_d = $signed(nxt[ACC_W-1:0]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  assign carry_o  = carry_q;
  assign borrow_o = borrow_q;

endmodule

// File: rtl/dlf_pi_loop_filter.sv
// DPLL loop filter: K-counter or PI mode driving a saturating control word
// around a programmable centre, with a two-stage sample pipeline.
module dlf_pi_loop_filter
  import dlf_pkg::*;
#(
  parameter int             W         = 8,
  parameter int             ACC_W     = 16,
  parameter int             KP_SHIFT  = 2,
  parameter int             KI_SHIFT  = 4,
  parameter logic [W-1:0]   INIT_WORD = 8'h80
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             freeze,
  input  logic             load,
  input  logic [W-1:0]     center_word,
  input  logic [ACC_W-2:0] k_mod,
  input  logic             pd_valid,
  input  logic             pd_lead,
  input  logic [W-1:0]     pd_mag,
  output logic [W-1:0]     ctrl_out,
  output logic             ctrl_valid,
  output logic             carry,
  output logic             borrow,
  output logic             sat
);

  logic [W-1:0]            ctrl_q;
  logic                    ctrl_valid_q, carry_q, borrow_q, sat_q;
  logic signed [ACC_W-1:0] integ_q, integ_d;
  logic signed [W:0]       e_q, e_c;
  logic                    pi_v_q;
  logic                    mode_q;

  logic                    flush, accept, kc_carry, kc_borrow;
  logic signed [ACC_W:0]   y_c;
  logic [31:0]             y_clamped;
  logic [W-1:0]            pi_word, k_word;
  logic                    pi_sat, k_sat;

  // A mode change between cycles flushes everything, including this cycle's sample.
  assign flush  = (mode != mode_q);
  assign accept = pd_valid && !freeze && !load && !flush;

  dlf_kcounter #(.ACC_W(ACC_W)) u_kcnt (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (load || flush),
    .step_i   (accept && (mode == MODE_KCNT)),
    .up_i     (pd_lead),
    .k_mod_i  (k_mod),
    .carry_o  (kc_carry),
    .borrow_o (kc_borrow)
  );

  always_comb begin
    e_c       = pd_lead ? $signed({1'b0, pd_mag}) : -$signed({1'b0, pd_mag});
    integ_d   = ACC_W'(sat_add_s(32'(integ_q), 32'(e_c), ACC_W));
    // integ_q already holds this sample's contribution when stage 2 runs.
    y_c       = (ACC_W+1)'($signed({1'b0, center_word}))
              + ((ACC_W+1)'(e_q) >>> KP_SHIFT)
              + ((ACC_W+1)'(integ_q) >>> KI_SHIFT);
    y_clamped = clamp_u(32'(y_c), W);
    pi_word   = y_clamped[W-1:0];
    pi_sat    = (y_clamped != $unsigned(32'(y_c)));
    k_sat     = kc_carry ? (ctrl_q == '1) : (ctrl_q == '0);
    if (k_sat)         k_word = ctrl_q;
    else if (kc_carry) k_word = ctrl_q + W'(1);
    else               k_word = ctrl_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q       <= INIT_WORD;
      ctrl_valid_q <= 1'b0;
      carry_q      <= 1'b0;
      borrow_q     <= 1'b0;
      sat_q        <= 1'b0;
      integ_q      <= '0;
      e_q          <= '0;
      pi_v_q       <= 1'b0;
      mode_q       <= mode;
    end else begin
      mode_q       <= mode;
      ctrl_valid_q <= 1'b0;
      carry_q      <= 1'b0;
      borrow_q     <= 1'b0;
      sat_q        <= 1'b0;
      if (load) begin
        ctrl_q       <= center_word;
        ctrl_valid_q <= 1'b1;
        integ_q      <= '0;
        pi_v_q       <= 1'b0;
      end else if (flush) begin
        integ_q <= '0;
        pi_v_q  <= 1'b0;
      end else begin
        pi_v_q <= accept && (mode == MODE_PI);
        if (accept && (mode == MODE_PI)) begin
          integ_q <= integ_d;
          e_q     <= e_c;
        end
        if (pi_v_q) begin
          ctrl_q       <= pi_word;
          sat_q        <= pi_sat;
          ctrl_valid_q <= 1'b1;
        end else if (kc_carry || kc_borrow) begin
          ctrl_q       <= k_word;
          sat_q        <= k_sat;
          carry_q      <= kc_carry;
          borrow_q     <= kc_borrow;
          ctrl_valid_q <= 1'b1;
        end
      end
    end
  end

  assign ctrl_out   = ctrl_q;
  assign ctrl_valid = ctrl_valid_q;
  assign carry      = carry_q;
  assign borrow     = borrow_q;
  assign sat        = sat_q;

endmodule

// File: tb/tb_dlf_pi_loop_filter.sv
// Directed bench for dlf_pi_loop_filter with hand-computed expected words.
module tb_dlf_pi_loop_filter;
  localparam int W     = 8;
  localparam int ACC_W = 16;

  logic             clk = 1'b0;
  logic             rst, mode, freeze, load;
  logic [W-1:0]     center_word, pd_mag;
  logic [ACC_W-2:0] k_mod;
  logic             pd_valid, pd_lead;
  logic [W-1:0]     ctrl_out;
  logic             ctrl_valid, carry, borrow, sat;

  int n_cmp = 0;
  int n_bad = 0;
  int vcnt  = 0;
  int v0;

  always #5 clk = ~clk;

  always @(negedge clk) if (ctrl_valid === 1'b1) vcnt <= vcnt + 1;

  dlf_pi_loop_filter dut (
    .clk(clk), .rst(rst), .mode(mode), .freeze(freeze), .load(load),
    .center_word(center_word), .k_mod(k_mod), .pd_valid(pd_valid),
    .pd_lead(pd_lead), .pd_mag(pd_mag), .ctrl_out(ctrl_out),
    .ctrl_valid(ctrl_valid), .carry(carry), .borrow(borrow), .sat(sat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] c);
    center_word = c;
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
  endtask

  task automatic send(input int n, input logic lead, input logic [W-1:0] mag);
    pd_valid = 1'b1;
    pd_lead  = lead;
    pd_mag   = mag;
    repeat (n) tick();
    pd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++; if (ctrl_out !== 8'h80) begin n_bad++; $display("FAIL reset_ctrl ctrl_out=%0h exp=80", ctrl_out); end
    n_cmp++; if ({ctrl_valid, carry, borrow, sat} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags got=%b exp=0000", {ctrl_valid, carry, borrow, sat}); end
  endtask

  task automatic test_pi_lead();
    mode = 1'b1;
    do_load(8'd128);
    pd_valid = 1'b1; pd_lead = 1'b1; pd_mag = 8'd16;
    tick();
    n_cmp++; if (ctrl_valid !== 1'b0) begin n_bad++; $display("FAIL pi_lead_early ctrl_valid=%b exp=0", ctrl_valid); end
    tick();
    pd_valid = 1'b0;
    n_cmp++; if (ctrl_valid !== 1'b1 || ctrl_out !== 8'd133) begin n_bad++; $display("FAIL pi_lead_1 valid=%b ctrl_out=%0d exp=1/133", ctrl_valid, ctrl_out); end
    tick();
    n_cmp++; if (ctrl_valid !== 1'b1 || ctrl_out !== 8'd134 || sat !== 1'b0) begin n_bad++; $display("FAIL pi_lead_2 valid=%b ctrl_out=%0d sat=%b exp=1/134/0", ctrl_valid, ctrl_out, sat); end
    n_cmp++; if (carry !== 1'b0 || borrow !== 1'b0) begin n_bad++; $display("FAIL pi_no_cb carry=%b borrow=%b exp=0/0", carry, borrow); end
    tick();
    n_cmp++; if (ctrl_valid !== 1'b0) begin n_bad++; $display("FAIL pi_lead_end ctrl_valid=%b exp=0", ctrl_valid); end
  endtask

  task automatic test_pi_lag();
    do_load(8'd128);
    send(1, 1'b0, 8'd16);
    tick();
    n_cmp++; if (ctrl_valid !== 1'b1 || ctrl_out !== 8'd123 || sat !== 1'b0) begin n_bad++; $display("FAIL pi_lag valid=%b ctrl_out=%0d sat=%b exp=1/123/0", ctrl_valid, ctrl_out, sat); end
  endtask

  task automatic test_kcnt();
    mode  = 1'b0;
    k_mod = 15'd4;
    do_load(8'd128);
    v0 = vcnt;
    send(4, 1'b1, 8'd0);
    n_cmp++; if (ctrl_valid !== 1'b0 || vcnt != v0) begin n_bad++; $display("FAIL kc_carry_early valid=%b pulses=%0d exp=0/0", ctrl_valid, vcnt - v0); end
    tick();
    n_cmp++; if (ctrl_valid !== 1'b1 || carry !== 1'b1 || borrow !== 1'b0 || ctrl_out !== 8'd129) begin n_bad++; $display("FAIL kc_carry valid=%b carry=%b borrow=%b ctrl_out=%0d exp=1/1/0/129", ctrl_valid, carry, borrow, ctrl_out); end
    tick();
    send(4, 1'b0, 8'd0);
    tick();
    n_cmp++; if (ctrl_valid !== 1'b1 || borrow !== 1'b1 || carry !== 1'b0 || ctrl_out !== 8'd128) begin n_bad++; $display("FAIL kc_borrow valid=%b carry=%b borrow=%b ctrl_out=%0d exp=1/0/1/128", ctrl_valid, carry, borrow, ctrl_out); end
    tick();
    v0 = vcnt;
    pd_valid = 1'b1; pd_lead = 1'b1;
    tick(); tick();
    pd_lead = 1'b0;
    tick(); tick();
    pd_valid = 1'b0;
    tick(); tick(); tick();
    n_cmp++; if (vcnt != v0 || ctrl_out !== 8'd128) begin n_bad++; $display("FAIL kc_mixed pulses=%0d ctrl_out=%0d exp=0/128", vcnt - v0, ctrl_out); end
    send(3, 1'b1, 8'd0);
    tick(); tick(); tick();
    n_cmp++; if (vcnt != v0) begin n_bad++; $display("FAIL kc_cnt_zero_3 pulses=%0d exp=0", vcnt - v0); end
    send(1, 1'b1, 8'd0);
    tick();
    n_cmp++; if (carry !== 1'b1 || ctrl_out !== 8'd129) begin n_bad++; $display("FAIL kc_cnt_zero_4 carry=%b ctrl_out=%0d exp=1/129", carry, ctrl_out); end
    tick();
    k_mod = 15'd0;
    send(1, 1'b0, 8'd0);
    tick();
    n_cmp++; if (borrow !== 1'b1 || ctrl_out !== 8'd128) begin n_bad++; $display("FAIL kc_kmod0 borrow=%b ctrl_out=%0d exp=1/128", borrow, ctrl_out); end
    tick();
    k_mod = 15'd1;
    do_load(8'd255);
    send(1, 1'b1, 8'd0);
    tick();
    n_cmp++; if (carry !== 1'b1 || ctrl_out !== 8'd255 || sat !== 1'b1) begin n_bad++; $display("FAIL kc_sat carry=%b ctrl_out=%0d sat=%b exp=1/255/1", carry, ctrl_out, sat); end
    tick();
  endtask

  task automatic test_pi_sat();
    mode = 1'b1;
    do_load(8'd252);
    send(1, 1'b1, 8'd255);
    tick();
    n_cmp++; if (ctrl_valid !== 1'b1 || ctrl_out !== 8'd255 || sat !== 1'b1) begin n_bad++; $display("FAIL pi_sat_hi valid=%b ctrl_out=%0d sat=%b exp=1/255/1", ctrl_valid, ctrl_out, sat); end
    tick();
    do_load(8'd2);
    send(1, 1'b0, 8'd255);
    tick();
    n_cmp++; if (ctrl_valid !== 1'b1 || ctrl_out !== 8'd0 || sat !== 1'b1) begin n_bad++; $display("FAIL pi_sat_lo valid=%b ctrl_out=%0d sat=%b exp=1/0/1", ctrl_valid, ctrl_out, sat); end
    tick();
  endtask

  task automatic test_priority();
    do_load(8'd128);
    v0 = vcnt;
    freeze = 1'b1;
    send(3, 1'b1, 8'd16);
    tick(); tick();
    freeze = 1'b0;
    n_cmp++; if (vcnt != v0 || ctrl_out !== 8'd128) begin n_bad++; $display("FAIL freeze pulses=%0d ctrl_out=%0d exp=0/128", vcnt - v0, ctrl_out); end
    send(1, 1'b1, 8'd16);
    tick();
    n_cmp++; if (ctrl_out !== 8'd133) begin n_bad++; $display("FAIL freeze_state ctrl_out=%0d exp=133", ctrl_out); end
    tick();
    center_word = 8'd100;
    load = 1'b1; pd_valid = 1'b1; pd_lead = 1'b1; pd_mag = 8'd16;
    tick();
    load = 1'b0; pd_valid = 1'b0;
    n_cmp++; if (ctrl_valid !== 1'b1 || ctrl_out !== 8'd100 || sat !== 1'b0) begin n_bad++; $display("FAIL load_wins valid=%b ctrl_out=%0d sat=%b exp=1/100/0", ctrl_valid, ctrl_out, sat); end
    tick();
    n_cmp++; if (ctrl_valid !== 1'b0 || ctrl_out !== 8'd100) begin n_bad++; $display("FAIL load_drop valid=%b ctrl_out=%0d exp=0/100", ctrl_valid, ctrl_out); end
    tick();
  endtask

  task automatic test_rst_mid();
    do_load(8'd50);
    send(1, 1'b1, 8'd16);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (ctrl_valid !== 1'b0 || ctrl_out !== 8'h80) begin n_bad++; $display("FAIL rst_mid valid=%b ctrl_out=%0h exp=0/80", ctrl_valid, ctrl_out); end
    tick();
    n_cmp++; if (ctrl_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_late valid=%b exp=0", ctrl_valid); end
  endtask

  task automatic test_mode_flush();
    mode = 1'b1;
    do_load(8'd128);
    v0 = vcnt;
    send(1, 1'b1, 8'd16);
    mode = 1'b0;
    tick();
    n_cmp++; if (ctrl_valid !== 1'b0 || ctrl_out !== 8'd128) begin n_bad++; $display("FAIL flush valid=%b ctrl_out=%0d exp=0/128", ctrl_valid, ctrl_out); end
    mode = 1'b1;
    tick(); tick();
    n_cmp++; if (vcnt != v0) begin n_bad++; $display("FAIL flush_pulses pulses=%0d exp=0", vcnt - v0); end
    send(1, 1'b1, 8'd16);
    tick();
    n_cmp++; if (ctrl_valid !== 1'b1 || ctrl_out !== 8'd133) begin n_bad++; $display("FAIL flush_integ valid=%b ctrl_out=%0d exp=1/133", ctrl_valid, ctrl_out); end
    tick();
  endtask

  initial begin
    rst = 1'b1; mode = 1'b1; freeze = 1'b0; load = 1'b0;
    center_word = '0; k_mod = 15'd4; pd_valid = 1'b0; pd_lead = 1'b0; pd_mag = '0;
    test_reset();
    test_pi_lead();
    test_pi_lag();
    test_kcnt();
    test_pi_sat();
    test_priority();
    test_rst_mid();
    test_mode_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
